// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed scan driver for a common-anode seven-segment display.
// Double-buffers a hex value so a frame never mixes old and new digits.
module seven_seg_scan_driver #(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned REFRESH_DIV   = 100000,
   parameter int unsigned BLANK_LEADING = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  value_valid,
   output logic                  value_ready,
   output logic [3:0]            digit_out,
   output logic [DIGITS-1:0]     anode_n,
   output logic                  dp_n
);

   localparam int unsigned PW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

   logic [PW-1:0]       pcnt;
   logic [IW-1:0]       idx;
   logic                pend;
   logic [4*DIGITS-1:0] pend_val;
   logic [4*DIGITS-1:0] disp_val;
   logic [DIGITS-1:0]   pend_dp;
   logic [DIGITS-1:0]   disp_dp;

   logic                tick;
   logic                frame_end;
   logic                accept;
   logic                lead;
   logic [DIGITS-1:0]   blank;
   logic [3:0]          sel_nib;
   logic                sel_dp;
   logic                sel_blank;
   logic [DIGITS-1:0]   sel_onehot;

   assign tick        = (pcnt == PMAX);
   assign frame_end   = tick && (idx == IMAX);
   assign value_ready = !pend && !reset;
   assign accept      = value_valid && value_ready;

   // Leading-zero detection, scanning from the most significant digit down.
   always_comb begin
      blank = '0;
      lead  = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         lead = lead && (disp_val[4*i +: 4] == 4'h0);
         if ((BLANK_LEADING != 0) && (i > 0)) begin
            blank[i] = lead;
         end
      end
   end

   // Select the slot addressed by idx.
   always_comb begin
      sel_nib    = 4'h0;
      sel_dp     = 1'b0;
      sel_blank  = 1'b0;
      sel_onehot = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx == IW'(i)) begin
            sel_nib       = disp_val[4*i +: 4];
            sel_dp        = disp_dp[i];
            sel_blank     = blank[i];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt      <= '0;
         idx       <= '0;
         pend      <= 1'b0;
         pend_val  <= '0;
         pend_dp   <= '0;
         disp_val  <= '0;
         disp_dp   <= '0;
         digit_out <= 4'h0;
         anode_n   <= '1;
         dp_n      <= 1'b1;
      end else begin
         pcnt <= tick ? '0 : pcnt + PW'(1);
         if (tick) begin
            idx <= (idx == IMAX) ? '0 : idx + IW'(1);
         end
         // Accept needs pend=0 and promote needs pend=1, so they never collide.
         if (accept) begin
            pend_val <= value_in;
            pend_dp  <= dp_in;
            pend     <= 1'b1;
         end else if (frame_end && pend) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
            pend     <= 1'b0;
         end
         digit_out <= sel_nib;
         anode_n   <= sel_blank ? '1 : ~sel_onehot;
         dp_n      <= sel_blank | ~sel_dp;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two instances (blanking on/off) share
// stimulus; a scoreboard of per-frame expected slot tables checks every cycle.
module tb_seven_seg_scan_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] vin;
   logic [3:0]  dpin;
   logic        valid;
   logic        value_ready, ready2;
   logic [3:0]  digit1, digit2;
   logic [3:0]  anode1, anode2;
   logic        dpn1, dpn2;

   always #5 clk = ~clk;

   seven_seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1)) dut (
      .clk(clk), .reset(reset), .value_in(vin), .dp_in(dpin), .value_valid(valid),
      .value_ready(value_ready), .digit_out(digit1), .anode_n(anode1), .dp_n(dpn1));

   seven_seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(0)) dut_nb (
      .clk(clk), .reset(reset), .value_in(vin), .dp_in(dpin), .value_valid(valid),
      .value_ready(ready2), .digit_out(digit2), .anode_n(anode2), .dp_n(dpn2));

   // Per-slot expectations packed {slot3,slot2,slot1,slot0}; frame = first frame shown.
   typedef struct {
      logic [15:0] val;
      logic [3:0]  dp;
      logic [15:0] dig;
      logic [15:0] an1;
      logic [3:0]  dp1;
      logic [15:0] an0;
      logic [3:0]  dp0;
      int          frame;
   } rec_t;

   rec_t tbl [9];
   rec_t sb [$];
   rec_t cur;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_rec(input int e, input logic [15:0] v, input logic [3:0] d,
                          input logic [15:0] a1, input logic [3:0] p1,
                          input logic [15:0] a0, input logic [3:0] p0);
      tbl[e].val = v;  tbl[e].dp = d;  tbl[e].dig = v;
      tbl[e].an1 = a1; tbl[e].dp1 = p1;
      tbl[e].an0 = a0; tbl[e].dp0 = p0;
      tbl[e].frame = 0;
   endtask

   // Monitor: samples just after each rising edge and compares both DUTs.
   initial begin
      int slot;
      forever begin
         @(posedge clk);
         #2;
         if (reset) begin
            cyc = 0;
            cur = tbl[0];
            check("reset_out", {23'd0, digit1, anode1, dpn1}, {23'd0, 4'h0, 4'hF, 1'b1});
            check("reset_out_nb", {23'd0, digit2, anode2, dpn2}, {23'd0, 4'h0, 4'hF, 1'b1});
            check("reset_ready", {31'd0, value_ready}, 32'd0);
         end else begin
            cyc++;
            slot = ((cyc - 1) / 4) % 4;
            if (((cyc - 1) % 16 == 0) && (sb.size() > 0) && (sb[0].frame == (cyc - 1) / 16))
               cur = sb.pop_front();
            check("slot_out", {23'd0, digit1, anode1, dpn1},
                  {23'd0, cur.dig[slot*4 +: 4], cur.an1[slot*4 +: 4], cur.dp1[slot]});
            check("slot_out_nb", {23'd0, digit2, anode2, dpn2},
                  {23'd0, cur.dig[slot*4 +: 4], cur.an0[slot*4 +: 4], cur.dp0[slot]});
         end
      end
   end

   // Offer a table entry; returns the accepting edge number.
   task automatic send(input int e, input bit hold, output int a);
      rec_t r;
      int   n;
      vin   = tbl[e].val;
      dpin  = tbl[e].dp;
      valid = 1'b1;
      n = 0;
      while (!value_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
      a = cyc + 1;
      r = tbl[e];
      r.frame = a / 16 + 1;
      sb.push_back(r);
      @(negedge clk);
      check("ready_drop", {31'd0, value_ready}, 32'd0);
      if (!hold) valid = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      repeat (n * 16) @(negedge clk);
   endtask

   initial begin
      int a, a1, a2, n;
      reset = 1'b1; vin = '0; dpin = '0; valid = 1'b0;
      //          val      dp       an1       dp1      an0       dp0
      set_rec(0, 16'h0000, 4'b0000, 16'hFFFE, 4'b1111, 16'h7BDE, 4'b1111);
      set_rec(1, 16'h12A0, 4'b0100, 16'h7BDE, 4'b1011, 16'h7BDE, 4'b1011);
      set_rec(2, 16'h0050, 4'b1000, 16'hFFDE, 4'b1111, 16'h7BDE, 4'b0111);
      set_rec(3, 16'h1111, 4'b0000, 16'h7BDE, 4'b1111, 16'h7BDE, 4'b1111);
      set_rec(4, 16'h2222, 4'b0001, 16'h7BDE, 4'b1110, 16'h7BDE, 4'b1110);
      set_rec(5, 16'h0807, 4'b0110, 16'hFBDE, 4'b1001, 16'h7BDE, 4'b1001);
      set_rec(6, 16'hBEEF, 4'b1111, 16'h7BDE, 4'b0000, 16'h7BDE, 4'b0000);
      set_rec(7, 16'h0000, 4'b0001, 16'hFFFE, 4'b1110, 16'h7BDE, 4'b1110);
      set_rec(8, 16'h0000, 4'b1111, 16'hFFFE, 4'b1110, 16'h7BDE, 4'b0000);
      cur = tbl[0];

      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1 check("ready_after_reset", {31'd0, value_ready}, 32'd1);
      repeat (32) @(negedge clk);

      for (int e = 1; e <= 2; e++) begin
         send(e, 1'b0, a);
         wait_frames(3);
      end

      // Back-to-back: second value waits for the promoting frame_end.
      send(3, 1'b1, a1);
      send(4, 1'b0, a2);
      check("b2b_accept_edge", a2, (a1 / 16 + 1) * 16 + 1);
      wait_frames(3);

      // Accept coinciding with frame_end.
      for (n = 0; n < 64 && cyc % 16 != 15; n++) @(negedge clk);
      check("ready_at_frame_end", {31'd0, value_ready}, 32'd1);
      send(5, 1'b0, a);
      check("fe_accept_edge", a % 16, 32'd0);
      wait_frames(3);

      // Reset at idx 2 while a value is pending.
      for (n = 0; n < 64 && cyc % 16 != 0; n++) @(negedge clk);
      send(6, 1'b0, a);
      for (n = 0; n < 64 && (cyc / 4) % 4 != 2; n++) @(negedge clk);
      check("pend_before_reset", {31'd0, value_ready}, 32'd0);
      sb.delete();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1 check("ready_after_midreset", {31'd0, value_ready}, 32'd1);
      wait_frames(3);

      for (int e = 7; e <= 8; e++) begin
         send(e, 1'b0, a);
         wait_frames(3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
